// File: rtl/alu_op_sequencer.sv
// Multi-cycle controller stepping one ALU operation through the register-transfer datapath:
// Ra->Y, ALU with Rb->Z, then Z writeback to Rz or to LO/HI for mul/div.
module alu_op_sequencer #(
   parameter int MULDIV_CYCLES = 4
) (
   input  logic       clock,
   input  logic       clear,
   input  logic       start,
   input  logic [4:0] op,
   output logic       busy,
   output logic       done,
   output logic       illegal,
   output logic       ra_out,
   output logic       rb_out,
   output logic       y_in,
   output logic       z_in,
   output logic [4:0] alu_control,
   output logic       z_lo_out,
   output logic       z_hi_out,
   output logic       rz_in,
   output logic       lo_in,
   output logic       hi_in
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOADY, S_EXEC, S_WBLO, S_WBHI, S_DONE
   } state_t;

   typedef struct packed {
      logic       busy;
      logic       done;
      logic       illegal;
      logic       ra_out;
      logic       rb_out;
      logic       y_in;
      logic       z_in;
      logic [4:0] alu_control;
      logic       z_lo_out;
      logic       z_hi_out;
      logic       rz_in;
      logic       lo_in;
      logic       hi_in;
   } out_t;

   localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

   state_t     state_q, state_d;
   logic [4:0] op_q, op_d;
   logic [3:0] cnt_q, cnt_d;
   out_t       out_q, out_d;

   function automatic logic is_legal(input logic [4:0] code);
      case (code)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
         5'd15, 5'd16, 5'd17, 5'd18: is_legal = 1'b1;
         default:                    is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic is_muldiv(input logic [4:0] code);
      is_muldiv = (code == 5'd15) || (code == 5'd16);
   endfunction

   function automatic logic is_binary(input logic [4:0] code);
      case (code)
         5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16: is_binary = 1'b1;
         default:                              is_binary = 1'b0;
      endcase
   endfunction

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d    = op;
               state_d = is_legal(op) ? S_LOADY : S_DONE;
            end
         end
         S_LOADY: begin
            state_d = S_EXEC;
            cnt_d   = is_muldiv(op_q) ? MD_LOAD : 4'd0;
         end
         S_EXEC: begin
            if (cnt_q == 4'd0) state_d = S_WBLO;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_WBLO:  state_d = is_muldiv(op_q) ? S_WBHI : S_DONE;
         S_WBHI:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the upcoming state so they register in step with it.
   always_comb begin
      out_d = '0;
      case (state_d)
         S_LOADY: begin
            out_d.busy   = 1'b1;
            out_d.ra_out = 1'b1;
            out_d.y_in   = 1'b1;
         end
         S_EXEC: begin
            out_d.busy        = 1'b1;
            out_d.alu_control = op_d;
            out_d.rb_out      = is_binary(op_d);
            out_d.z_in        = (cnt_d == 4'd0);
         end
         S_WBLO: begin
            out_d.busy     = 1'b1;
            out_d.z_lo_out = 1'b1;
            out_d.lo_in    = is_muldiv(op_d);
            out_d.rz_in    = !is_muldiv(op_d);
         end
         S_WBHI: begin
            out_d.busy     = 1'b1;
            out_d.z_hi_out = 1'b1;
            out_d.hi_in    = 1'b1;
         end
         S_DONE: begin
            out_d.done    = 1'b1;
            out_d.illegal = !is_legal(op_d);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q <= S_IDLE;
         op_q    <= 5'd0;
         cnt_q   <= 4'd0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign busy        = out_q.busy;
   assign done        = out_q.done;
   assign illegal     = out_q.illegal;
   assign ra_out      = out_q.ra_out;
   assign rb_out      = out_q.rb_out;
   assign y_in        = out_q.y_in;
   assign z_in        = out_q.z_in;
   assign alu_control = out_q.alu_control;
   assign z_lo_out    = out_q.z_lo_out;
   assign z_hi_out    = out_q.z_hi_out;
   assign rz_in       = out_q.rz_in;
   assign lo_in       = out_q.lo_in;
   assign hi_in       = out_q.hi_in;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: per-cycle expected strobe trace plus a small
// register-transfer datapath whose results are checked when done is seen.
module tb_alu_op_sequencer;

   localparam int MD = 4;

   logic       clock = 1'b0;
   logic       clear, start;
   logic [4:0] op;
   logic       busy, done, illegal, ra_out, rb_out, y_in, z_in;
   logic [4:0] alu_control;
   logic       z_lo_out, z_hi_out, rz_in, lo_in, hi_in;

   alu_op_sequencer #(.MULDIV_CYCLES(MD)) dut (
      .clock(clock), .clear(clear), .start(start), .op(op),
      .busy(busy), .done(done), .illegal(illegal),
      .ra_out(ra_out), .rb_out(rb_out), .y_in(y_in), .z_in(z_in),
      .alu_control(alu_control), .z_lo_out(z_lo_out), .z_hi_out(z_hi_out),
      .rz_in(rz_in), .lo_in(lo_in), .hi_in(hi_in)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          md;
      logic [63:0] v;
   } res_t;

   logic [16:0] exp_q[$];
   res_t        res_q[$];
   int          vectors = 0;
   int          fails = 0;
   bit          mon_en = 1'b0;

   int legal_ops[13]  = '{3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 16, 17, 18};
   int binary_ops[6]  = '{3, 4, 5, 6, 15, 16};

   function automatic bit in_list_legal(input logic [4:0] o);
      foreach (legal_ops[i]) if (int'(o) == legal_ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit in_list_binary(input logic [4:0] o);
      foreach (binary_ops[i]) if (int'(o) == binary_ops[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [16:0] w(input bit bsy, dn, ill, ra, rb, y, z,
                                     input logic [4:0] alu,
                                     input bit zlo, zhi, rz, lo, hi);
      return {bsy, dn, ill, ra, rb, y, z, alu, zlo, zhi, rz, lo, hi};
   endfunction

   // Reference ALU: 32-bit ops return the result in the low word; div gives {rem, quot}.
   function automatic logic [63:0] alu_fn(input logic [4:0] o, input logic [31:0] a, b);
      logic [31:0] r;
      case (o)
         5'd3:  r = a + b;
         5'd4:  r = a - b;
         5'd5:  r = a & b;
         5'd6:  r = a | b;
         5'd7:  r = a >> 1;
         5'd8:  r = {a[31], a[31:1]};
         5'd9:  r = a << 1;
         5'd10: r = {a[0], a[31:1]};
         5'd11: r = {a[30:0], a[31]};
         5'd15: return {32'd0, a} * {32'd0, b};
         5'd16: return (b == 32'd0) ? 64'd0 : {a % b, a / b};
         5'd17: r = 32'd0 - a;
         5'd18: r = ~a;
         default: r = 32'd0;
      endcase
      return {32'd0, r};
   endfunction

   // Datapath driven by the DUT strobes.
   logic [31:0] ra_v, rb_v, y_m, rz_m, lo_m, hi_m, bus;
   logic [63:0] z_m;

   always_comb begin
      bus = 32'd0;
      if (ra_out)        bus = ra_v;
      else if (rb_out)   bus = rb_v;
      else if (z_lo_out) bus = z_m[31:0];
      else if (z_hi_out) bus = z_m[63:32];
   end

   always @(posedge clock) begin
      if (y_in)  y_m  <= bus;
      if (z_in)  z_m  <= alu_fn(alu_control, y_m, bus);
      if (rz_in) rz_m <= bus;
      if (lo_in) lo_m <= bus;
      if (hi_in) hi_m <= bus;
   end

   // Monitor: one trace comparison per cycle, one result comparison per legal done.
   logic [16:0] got_w, exp_w;
   res_t        r_exp;
   always @(negedge clock) begin
      if (mon_en) begin
         got_w = {busy, done, illegal, ra_out, rb_out, y_in, z_in, alu_control,
                  z_lo_out, z_hi_out, rz_in, lo_in, hi_in};
         exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 17'd0;
         vectors++;
         if (got_w !== exp_w) begin
            fails++;
            $display("FAIL trace t=%0t got=%05h exp=%05h", $time, got_w, exp_w);
         end
         if (done === 1'b1 && illegal === 1'b0) begin
            vectors++;
            if (res_q.size() == 0) begin
               fails++;
               $display("FAIL result t=%0t got=done exp=no pending op", $time);
            end else begin
               r_exp = res_q.pop_front();
               if (r_exp.md) begin
                  if ({hi_m, lo_m} !== r_exp.v) begin
                     fails++;
                     $display("FAIL hilo t=%0t got=%016h exp=%016h", $time, {hi_m, lo_m}, r_exp.v);
                  end
               end else if (rz_m !== r_exp.v[31:0]) begin
                  fails++;
                  $display("FAIL rz t=%0t got=%08h exp=%08h", $time, rz_m, r_exp.v[31:0]);
               end
            end
         end
      end
   end

   task automatic push_expect(input logic [4:0] o, input logic [31:0] a, b);
      bit md, bin;
      int n;
      res_t r;
      md  = (o == 5'd15) || (o == 5'd16);
      bin = in_list_binary(o);
      if (!in_list_legal(o)) begin
         exp_q.push_back(w(0, 1, 1, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0));
         return;
      end
      exp_q.push_back(w(1, 0, 0, 1, 0, 1, 0, 5'd0, 0, 0, 0, 0, 0));
      n = md ? MD : 1;
      for (int i = 1; i <= n; i++)
         exp_q.push_back(w(1, 0, 0, 0, bin, 0, (i == n), o, 0, 0, 0, 0, 0));
      exp_q.push_back(w(1, 0, 0, 0, 0, 0, 0, 5'd0, 1, 0, !md, md, 0));
      if (md) exp_q.push_back(w(1, 0, 0, 0, 0, 0, 0, 5'd0, 0, 1, 0, 0, 1));
      exp_q.push_back(w(0, 1, 0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 0, 0));
      r.md = md;
      r.v  = alu_fn(o, a, bin ? b : 32'd0);
      res_q.push_back(r);
   endtask

   task automatic idle_wait();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clock);
         n++;
      end
      if (exp_q.size() != 0) begin
         vectors++;
         fails++;
         $display("FAIL idle_wait got=%0d pending exp=0", exp_q.size());
         exp_q.delete();
         res_q.delete();
      end
      @(negedge clock);
      #1;
   endtask

   task automatic issue(input logic [4:0] o, input logic [31:0] a, b);
      idle_wait();
      ra_v  = a;
      rb_v  = b;
      start = 1'b1;
      op    = o;
      push_expect(o, a, b);
      @(negedge clock);
      #1;
      start = 1'b0;
      op    = 5'($urandom);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [4:0]  o;
      logic [31:0] a, b;
      clear = 1'b0;
      start = 1'b0;
      op    = 5'd0;
      ra_v  = 32'd0;
      rb_v  = 32'd0;
      repeat (2) @(posedge clock);
      #1;
      mon_en = 1'b1;
      @(negedge clock);
      #1;
      clear = 1'b1;

      issue(5'd3, 32'd5, 32'd7);
      issue(5'd15, 32'h10000, 32'h10000);
      issue(5'd18, 32'd0, 32'h1234);
      issue(5'd18, 32'hA5A5_0F0F, 32'd0);
      issue(5'd31, 32'd1, 32'd2);

      // Start held through LOADY..DONE of an add must be ignored.
      issue(5'd3, 32'd100, 32'd23);
      start = 1'b1;
      op    = 5'd3;
      repeat (4) begin
         @(negedge clock);
         #1;
      end
      start = 1'b0;

      // Abort a div in EXEC.
      issue(5'd16, 32'd1000, 32'd7);
      @(negedge clock);
      #1;
      clear = 1'b0;
      exp_q.delete();
      res_q.delete();
      @(negedge clock);
      #1;
      clear = 1'b1;
      repeat (12) @(negedge clock);
      #1;
      issue(5'd3, 32'hFFFF_FFFF, 32'd2);
      issue(5'd16, 32'd1000, 32'd7);

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 3) == 0) o = 5'($urandom_range(0, 31));
         else o = 5'(legal_ops[$urandom_range(0, 12)]);
         a = $urandom;
         b = $urandom;
         if (o == 5'd16 && b == 32'd0) b = 32'd1;
         issue(o, a, b);
      end

      idle_wait();
      repeat (3) @(negedge clock);
      #1;
      vectors++;
      if (res_q.size() != 0) begin
         fails++;
         $display("FAIL leftover got=%0d results exp=0", res_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Multi-cycle controller that sequences one ALU operation through the register-transfer datapath.
- It gates the Ra source onto the bus and loads Y, drives the 5-bit ALU control code while gating Rb and loading Z, then writes back Z.
- Writeback goes to Rz for single-result ops, or to LO and HI for mul/div.
- It sits between the instruction control unit (start/op handshake) and the datapath register enables.

Parameters:
- MULDIV_CYCLES, 4, number of cycles alu_control is held stable for mul/div before z_in is strobed; legal range 1..15.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  synchronous, active-low reset.
- start  in  1  request to run op; sampled only in IDLE.
- op  in  5  ALU code: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg, 10010 not.
- busy  out  1  high in LOADY, EXEC, WBLO and WBHI.
- done  out  1  one-cycle pulse in the DONE state.
- illegal  out  1  one-cycle pulse with done when the latched op is not in the list above.
- ra_out  out  1  gate Ra onto the bus.
- rb_out  out  1  gate Rb onto the bus.
- y_in  out  1  load Y.
- z_in  out  1  load Z.
- alu_control  out  5  code driven to the ALU.
- z_lo_out  out  1  gate Z[31:0] onto the bus.
- z_hi_out  out  1  gate Z[63:32] onto the bus.
- rz_in  out  1  load the destination register.
- lo_in  out  1  load LO.
- hi_in  out  1  load HI.

Behaviour:
- All outputs are registered Moore outputs decoded from state.
- clear low at a clock edge:
  - state becomes IDLE; latched op and the exec counter become 0.
  - every output is 0 in the following cycle.
  - This applies in any state, including mid-operation; no further strobes are issued for the aborted op.
- States are IDLE, LOADY, EXEC, WBLO, WBHI, DONE.
- IDLE:
  - all outputs 0.
  - start=1 at an edge latches op.
  - Next state is LOADY if op is legal, otherwise DONE with illegal=1.
- LOADY:
  - ra_out=1, y_in=1.
  - Next state is EXEC; the exec counter loads MULDIV_CYCLES-1 for mul/div, else 0.
- EXEC:
  - alu_control = latched op.
  - rb_out=1 for binary ops (add, sub, and, or, mul, div); rb_out=0 for unary ops (shifts, rotates, neg, not).
  - z_in=1 only when the counter is 0; otherwise the counter decrements and the state stays EXEC with alu_control held stable.
  - When the counter is 0, next state is WBLO.
- WBLO:
  - z_lo_out=1.
  - rz_in=1 for non-mul/div ops; lo_in=1 for mul/div.
  - Next state is WBHI for mul/div, else DONE.
- WBHI:
  - z_hi_out=1, hi_in=1.
  - Next state is DONE.
- DONE:
  - done=1; illegal=1 if the op is illegal.
  - Next state is IDLE.
- alu_control is 00000 in every state except EXEC. The ALU evaluates on a code change, so back-to-back identical ops must each see a 00000 to op transition.
- At most one bus-source gate (ra_out, rb_out, z_lo_out, z_hi_out) is high in any cycle.
- start while not in IDLE, including DONE, is ignored; there is no queueing.
- op may change freely after the start edge; only the latched copy is used.
- Latency from the start edge to the cycle done is high:
  - 4 cycles for single-result ops.
  - MULDIV_CYCLES+4 cycles for mul/div (8 at the default).
  - 1 cycle for illegal ops.
- Minimum start-to-start spacing is latency+1, because IDLE is revisited between ops.

Test Plan:
- Reset, then start=1 with op=00011 (add): cycle 1 ra_out=y_in=1; cycle 2 alu_control=00011, rb_out=z_in=1; cycle 3 z_lo_out=rz_in=1; cycle 4 done=1, busy=0. Datapath with Ra=5, Rb=7 gives Rz=12.
- op=01111 (mul) with MULDIV_CYCLES=4: alu_control=01111 held 4 cycles and z_in high only in the 4th; lo_in then hi_in in consecutive cycles; done at cycle 8. Ra=0x10000, Rb=0x10000 gives LO=0, HI=1.
- op=10010 (not): rb_out=0 throughout; Ra=0 gives Rz=0xFFFFFFFF. Two back-to-back not ops show alu_control returning to 00000 between them.
- op=11111: next cycle done=1, illegal=1, no strobes; start pulsed while busy during an add is ignored, and exactly one done is seen.
- clear=0 asserted in EXEC of a div: the following cycle has all outputs 0 and state IDLE, with no lo_in, hi_in or done afterwards. A new add then completes normally.
